// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM encoding, block width, default depth and stream byte order.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int unsigned BLOCK_W       = 128;
    localparam int unsigned DEPTH_DEFAULT = 1024;
    localparam bit          BYTE_ORDER_LE = 1'b1;

    // Drop one stream byte into its lane of the instruction word being assembled.
    function automatic logic [31:0] place_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
        logic [31:0] w;
        logic [1:0]  l;
        w = word;
        l = BYTE_ORDER_LE ? lane : ~lane;
        w[{l, 3'b000} +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> checksum-verified instruction-memory image; holds the core in reset until done.
// Define IMEM_LOADER_ENCRYPT_EN to pass each block through the codebase `encrypt` (i_block -> o_block) first.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               im_we,
    output logic [AW-1:0]      im_addr,
    output logic [BLOCK_W-1:0] im_wdata,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_err,
    output logic [15:0]        words_loaded
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t               r_state;
    logic [15:0]          r_n;
    logic [1:0]           r_byte_cnt;
    logic [31:0]          r_word;
    logic [15:0]          r_word_idx;
    logic [7:0]           r_xor;
    logic                 r_ready;
    logic                 r_we;
    logic [AW-1:0]        r_addr;
    logic [BLOCK_W-1:0]   r_wdata;
    logic [15:0]          r_words_loaded;
    logic                 r_cpu_reset;
    logic                 r_done;
    logic                 r_err;

    logic                 w_accept;
    logic [15:0]          w_n;
    logic [15:0]          w_idx_next;
    logic [31:0]          w_word;
    logic [BLOCK_W-1:0]   w_plain;
    logic [BLOCK_W-1:0]   w_block;

    assign w_accept   = in_valid && r_ready;
    assign w_n        = {in_data, r_n[7:0]};
    assign w_idx_next = r_word_idx + 16'd1;
    assign w_word     = place_byte(r_word, r_byte_cnt, in_data);
    assign w_plain    = {{(BLOCK_W-32){1'b0}}, w_word};

`ifdef IMEM_LOADER_ENCRYPT_EN
    encrypt u_encrypt (
        .i_block (w_plain),
        .o_block (w_block)
    );
`else
    assign w_block = w_plain;
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state        <= ST_HDR0;
            r_n            <= '0;
            r_byte_cnt     <= '0;
            r_word         <= '0;
            r_word_idx     <= '0;
            r_xor          <= '0;
            r_ready        <= 1'b1;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_words_loaded <= '0;
            r_cpu_reset    <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    ST_HDR0: begin
                        r_n[7:0] <= in_data;
                        r_xor    <= r_xor ^ in_data;
                        r_state  <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        r_n   <= w_n;
                        r_xor <= r_xor ^ in_data;
                        if (w_n > DEPTH16) begin
                            r_state <= ST_ERROR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else if (w_n == 16'd0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_xor      <= r_xor ^ in_data;
                        r_word     <= w_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            // Write and count advance together so words_loaded tracks im_we exactly.
                            r_we           <= 1'b1;
                            r_addr         <= r_word_idx[AW-1:0];
                            r_wdata        <= w_block;
                            r_word_idx     <= w_idx_next;
                            r_words_loaded <= w_idx_next;
                            if (w_idx_next == r_n) begin
                                r_state <= ST_CSUM;
                            end
                        end
                    end
                    ST_CSUM: begin
                        r_ready <= 1'b0;
                        if (in_data == r_xor) begin
                            r_state     <= ST_DONE;
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready     = r_ready;
    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign words_loaded = r_words_loaded;
    assign cpu_reset    = r_cpu_reset;
    assign load_done    = r_done;
    assign load_err     = r_err;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory. It accepts a byte stream (typically from a UART receiver), assembles 32-bit instruction words, and optionally encrypts them into 128-bit blocks. It writes them to consecutive instruction-memory addresses and holds the processor core in reset until a complete, checksum-verified image has been written.

## Interface
- DEPTH, 1024: instruction-memory depth in words; maximum loadable word count.
- AW, 10: address width, $clog2(DEPTH).
- clk  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high; restarts loading.
- in_valid  in  1  byte available on in_data.
- in_ready  out  1  loader can accept a byte.
- in_data  in  8  stream byte.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  AW  word address for the write.
- im_wdata  out  128  block written to instruction memory.
- cpu_reset  out  1  drives the core's RESET; high until load succeeds.
- load_done  out  1  image loaded and checksum matched.
- load_err  out  1  length overflow or checksum mismatch.
- words_loaded  out  16  count of words written so far.

## Operation
- Byte transfer: a byte is accepted on a rising edge when in_valid && in_ready.
- Stream format:
  - 16-bit word count N, low byte first.
  - N words, 4 bytes each, little-endian (first byte → bits 7:0).
  - One checksum byte equal to the XOR of every preceding byte, including the header.
- FSM states: HDR0 → HDR1 → DATA → CSUM → DONE, plus ERROR.
  - HDR0: latch N[7:0].
  - HDR1: latch N[15:8], then evaluate N:
    - N > DEPTH: go to ERROR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: shift in bytes using a 2-bit byte counter. On the 4th byte, register the word, increment the word index, and go to CSUM after word N.
  - CSUM: compare the received byte with the running XOR. Match goes to DONE; mismatch goes to ERROR.
  - DONE and ERROR are terminal until RESET.
- in_ready: 1 in HDR0, HDR1, DATA and CSUM; 0 in DONE and ERROR.
- Write data: im_wdata = encrypt({96'd0, word}) or {96'd0, word}; see Configuration.
- Write address: im_addr is the word index 0..N-1 and wraps only through RESET.
- cpu_reset: 1 in every state except DONE.
- load_done: 1 only in DONE.
- load_err: 1 only in ERROR.
- Reset values: state = HDR0, all counters and the XOR accumulator = 0, im_we = 0, im_addr = 0, im_wdata = 0, words_loaded = 0, cpu_reset = 1, load_done = 0, load_err = 0.
- RESET mid-load: abandon the partial word and restart at HDR0. Instruction-memory contents are not cleared.

## Timing
- Write latency: im_we pulses on the cycle after the edge that accepts a word's 4th byte. im_addr and im_wdata are valid in that same cycle.
- No back-pressure during writes: the loader may accept the next byte in the same cycle im_we is high.
- Checksum: the byte is accepted at edge k; at edge k+1 the FSM is in DONE or ERROR.
- Release: cpu_reset falls on the cycle after the checksum edge, so the core's first fetch sees every write complete.
- Back-to-back: with in_valid held high, loading N words takes 2 + 4N + 1 accepted bytes.
- words_loaded: increments together with im_we and saturates at N.
- in_valid while in_ready = 0: the byte is ignored and the FSM state does not change.

## Configuration
- IMEM_LOADER_ENCRYPT_EN defined:
  - Instantiate the codebase `encrypt` module on {96'd0, word}.
  - Register its 128-bit output as im_wdata.
- Undefined:
  - im_wdata = {96'd0, word}, and no `encrypt` instance exists.
  - Only use this when the matching `decrypt` on the fetch path is also removed.
- Cycle timing is identical in both builds.

## Structure
- Shared package:
  - FSM state encoding (HDR0, HDR1, DATA, CSUM, DONE, ERROR).
  - BLOCK_W = 128.
  - DEPTH default.
  - Byte-order constant (little-endian).
- Sub-modules: the existing `encrypt` (under the macro) is the only one. Byte assembly and the FSM stay in imem_loader.

## Test plan
- Nominal load: stream 02 00, 13 00 00 00, 37 00 00 00, checksum 0x26 (0x02 ^ 0x13 ^ 0x37). Expect:
  - Two im_we pulses: addr 0 with low word 0x00000013, then addr 1 with low word 0x00000037.
  - Then load_done = 1, cpu_reset = 0, words_loaded = 2.
- Bad checksum: same stream with final byte 0x27 → load_err = 1, cpu_reset stays 1, in_ready = 0.
- Zero length: stream 00 00 00 → no im_we, load_done = 1.
- Overflow: header 01 04 (N = 1025) with DEPTH = 1024 → ERROR right after HDR1, no writes.
- RESET mid-load: assert RESET after byte 2 of word 1, then send a full valid stream → addresses restart at 0 and load_done = 1.
- Gapped in_valid: a valid stream with random stalls → same writes and result as the nominal load.
- Encryption build: with IMEM_LOADER_ENCRYPT_EN defined, im_wdata equals the `encrypt` reference output. With it undefined, bits 127:32 are 0.
